bridge_hub: RTL



---
 rtl/bridge_pkg.sv | 20 ++
 rtl/bridge_frame_fifo.sv | 91 +++++++++
 rtl/bridge_hub.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: egress FSM states, default sizing and round-robin helper
// shared by the bridge_hub frame hub.
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } egress_state_t;

   localparam int DEF_DEPTH = 2048;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);
   localparam int DEF_PW    = DEF_AW + 1;

   function automatic int unsigned rr_next(input int unsigned p,
                                           input int unsigned n);
      return (p + 1 >= n) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/bridge_frame_fifo.sv
// bridge_frame_fifo: per-port store-and-forward FIFO committing whole frames.
// BRIDGE_ERR_DROP_EN: discard frames whose last beat carries in_err.
module bridge_frame_fifo
   import bridge_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_err,
   input  logic              fetch,
   input  logic              frame_done,
   output logic [DATA_W:0]   q,
   output logic              has_frame,
   output logic              drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

`ifdef BRIDGE_ERR_DROP_EN
   localparam bit ERR_DROP = 1'b1;
`else
   localparam bit ERR_DROP = 1'b0;
`endif

   logic [DATA_W:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   commit_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   frame_cnt;
   logic            overrun;
   logic            full;
   logic            wr_en;
   logic            err_hit;
   logic            discard;
   logic            commit;

   // Free space is measured against rd_ptr so bytes already fetched
   // into the egress registers release their slots immediately.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en   = in_valid & ~overrun & ~full;
   assign err_hit = ERR_DROP & in_err;
   assign discard = in_valid & in_last & (overrun | full | err_hit);
   assign commit  = in_valid & in_last & ~discard;

   assign has_frame = (frame_cnt != '0);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
      if (fetch)
         q <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         frame_cnt  <= '0;
         overrun    <= 1'b0;
         drop       <= 1'b0;
      end else begin
         drop <= discard;
         if (discard) begin
            wr_ptr  <= commit_ptr;
            overrun <= 1'b0;
         end else begin
            if (wr_en)
               wr_ptr <= wr_ptr + 1'b1;
            if (in_valid & full)
               overrun <= 1'b1;
            if (commit)
               commit_ptr <= wr_ptr + 1'b1;
         end
         if (fetch)
            rd_ptr <= rd_ptr + 1'b1;
         if (commit & ~frame_done)
            frame_cnt <= frame_cnt + 1'b1;
         else if (frame_done & ~commit)
            frame_cnt <= frame_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/bridge_hub.sv
// bridge_hub: NUM_PORTS-way store-and-forward flooding hub, round-robin egress.
// BRIDGE_ERR_DROP_EN (optional): drop ingress frames ending with in_err.
module bridge_hub
   import bridge_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS-1:0]          in_last,
   input  logic [NUM_PORTS-1:0]          in_err,
   output logic [NUM_PORTS-1:0]          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_last,
   input  logic [NUM_PORTS-1:0]          out_ready,
   output logic [NUM_PORTS-1:0]          drop
);

   localparam int SW = $clog2(NUM_PORTS);

   egress_state_t   state, state_nxt;
   logic [SW-1:0]   src, src_nxt;
   logic [SW-1:0]   rr, rr_nxt;
   logic            ov, ov_nxt;
   logic [DATA_W-1:0] od, od_nxt;
   logic            ol, ol_nxt;
   logic            qv, qv_nxt;
   logic            fetch_any;
   logic            done;
   logic            accept;
   logic            found;
   logic [SW-1:0]   pick;
   logic [SW-1:0]   idx;

   logic [DATA_W:0]      fq [NUM_PORTS];
   logic [DATA_W:0]      sel_q;
   logic [NUM_PORTS-1:0] has_frame;
   logic [NUM_PORTS-1:0] src_oh;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign src_oh[p] = (src == SW'(p));

      bridge_frame_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid[p]),
         .in_data    (in_data[p*DATA_W +: DATA_W]),
         .in_last    (in_last[p]),
         .in_err     (in_err[p]),
         .fetch      (fetch_any & src_oh[p]),
         .frame_done (done & src_oh[p]),
         .q          (fq[p]),
         .has_frame  (has_frame[p]),
         .drop       (drop[p])
      );
   end

   assign sel_q     = fq[src];
   assign accept    = ov & (&(out_ready | src_oh));
   assign out_valid = {NUM_PORTS{ov}} & ~src_oh;
   assign out_data  = od;
   assign out_last  = ol;

   // The FIFO read register acts as a one-beat prefetch (qv) behind the
   // output register; a fetch follows every non-last byte, never more.
   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      rr_nxt    = rr;
      ov_nxt    = ov;
      od_nxt    = od;
      ol_nxt    = ol;
      qv_nxt    = qv;
      fetch_any = 1'b0;
      done      = 1'b0;
      found     = 1'b0;
      pick      = src;
      idx       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = SW'((int'(rr) + i) % NUM_PORTS);
         if (!found && has_frame[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      unique case (state)
         IDLE: begin
            if (found) begin
               src_nxt   = pick;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            fetch_any = 1'b1;
            qv_nxt    = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            if (accept && ol) begin
               ov_nxt    = 1'b0;
               ol_nxt    = 1'b0;
               done      = 1'b1;
               rr_nxt    = SW'(rr_next(32'(src), NUM_PORTS));
               state_nxt = IDLE;
            end else if ((!ov || accept) && qv) begin
               ov_nxt    = 1'b1;
               od_nxt    = sel_q[DATA_W-1:0];
               ol_nxt    = sel_q[DATA_W];
               qv_nxt    = ~sel_q[DATA_W];
               fetch_any = ~sel_q[DATA_W];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         src   <= '0;
         rr    <= '0;
         ov    <= 1'b0;
         od    <= '0;
         ol    <= 1'b0;
         qv    <= 1'b0;
      end else begin
         state <= state_nxt;
         src   <= src_nxt;
         rr    <= rr_nxt;
         ov    <= ov_nxt;
         od    <= od_nxt;
         ol    <= ol_nxt;
         qv    <= qv_nxt;
      end
   end

endmodule
